// File: rtl/serial_frame_rx_if.sv
// Output port of serial_frame_rx: received word with valid/ready handshake.
//   out_data  : received word
//   out_valid : out_data holds an unconsumed word
//   out_ready : consumer accepts the word when high together with out_valid
//   out_perr  : parity error flag belonging to the word on out_data
interface serial_frame_rx_if #(
  parameter int unsigned W = 4
);
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_perr;

  // Producer side (the receiver)
  modport master (
    output out_data,
    output out_valid,
    output out_perr,
    input  out_ready
  );

  // Consumer side
  modport slave (
    input  out_data,
    input  out_valid,
    input  out_perr,
    output out_ready
  );
endinterface

// File: rtl/serial_frame_rx.sv
// Serial frame receiver fed by the shift register MSB output.
// Frame: start(0), W data bits LSB first, optional parity, stop(1).
//   clk, rst_n : clock, synchronous active-low reset
//   sin        : serial data bit, sampled only when sample_en is high
//   sample_en  : bit strobe
//   out_if     : word output (data, valid, ready, perr)
//   frame_err  : sticky, stop bit sampled as 0
//   overrun    : sticky, good frame completed while holding register full
//   err_clr    : clears frame_err and overrun (a coincident set wins)
//   busy       : FSM not in IDLE
module serial_frame_rx #(
  parameter int unsigned W      = 4,
  parameter int unsigned PARITY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sin,
  input  logic                  sample_en,
  serial_frame_rx_if.master     out_if,
  output logic                  frame_err,
  output logic                  overrun,
  input  logic                  err_clr,
  output logic                  busy
);

  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } state_e;

  state_e         state_q,     state_d;
  logic [CW-1:0]  cnt_q,       cnt_d;
  logic [W-1:0]   shift_q,     shift_d;
  logic           perr_pend_q, perr_pend_d;
  logic [W-1:0]   data_q,      data_d;
  logic           valid_q,     valid_d;
  logic           perr_q,      perr_d;
  logic           ferr_q,      ferr_d;
  logic           ovr_q,       ovr_d;
  logic           busy_q,      busy_d;

  logic           take_c;
  logic           par_x_c;

  // Next-state and output computation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    perr_pend_d = perr_pend_q;
    data_d      = data_q;
    valid_d     = valid_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    ovr_d       = ovr_q;
    take_c      = valid_q & out_if.out_ready;
    par_x_c     = ^{shift_q, sin};

    if (take_c) valid_d = 1'b0;

    // Clear first so that a set event later in this block wins
    if (err_clr) begin
      ferr_d = 1'b0;
      ovr_d  = 1'b0;
    end

    if (sample_en) begin
      unique case (state_q)
        IDLE: begin
          if (!sin) begin
            state_d     = DATA;
            cnt_d       = '0;
            perr_pend_d = 1'b0;
          end
        end
        DATA: begin
          for (int unsigned i = 0; i < W; i++) begin
            if (cnt_q == CW'(i)) shift_d[i] = sin;
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(W - 1)) state_d = (PARITY != 0) ? PAR : STOP;
        end
        PAR: begin
          perr_pend_d = (PARITY == 2) ? ~par_x_c : par_x_c;
          state_d     = STOP;
        end
        STOP: begin
          if (sin) begin
            // Load if the holding register is free or drains this cycle
            if (!valid_q || take_c) begin
              data_d  = shift_q;
              perr_d  = perr_pend_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      perr_pend_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      perr_pend_q <= perr_pend_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      ovr_q       <= ovr_d;
      busy_q      <= busy_d;
    end
  end

  assign out_if.out_data  = data_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_perr  = perr_q;
  assign frame_err        = ferr_q;
  assign overrun          = ovr_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx (W=4, even parity).
module tb_serial_frame_rx;

  logic clk = 1'b0;
  logic rst_n;
  logic sin;
  logic sample_en;
  logic err_clr;
  logic frame_err;
  logic overrun;
  logic busy;

  int cmp_cnt = 0;
  int err_cnt = 0;

  serial_frame_rx_if #(.W(4)) bus ();

  serial_frame_rx #(.W(4), .PARITY(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .sample_en (sample_en),
    .out_if    (bus),
    .frame_err (frame_err),
    .overrun   (overrun),
    .err_clr   (err_clr),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: even parity error = XOR over data and received parity bit
  function automatic logic ref_perr(input logic [3:0] d, input logic p);
    logic x;
    x = p;
    for (int i = 0; i < 4; i++) x = x ^ d[i];
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // gap idle cycles (random sin, no strobe) precede the strobed bit
  task automatic send_bit(input logic b, input int gap);
    for (int g = 0; g < gap; g++) begin
      sample_en = 1'b0;
      sin = 1'($urandom);
      tick();
    end
    sin = b;
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
  endtask

  // Full frame; out_ready is driven to rdy_stop during the stop strobe only
  task automatic send_frame(input logic [3:0] d, input logic p, input logic stop,
                            input int gap, input logic rdy_stop);
    logic [3:0] dv;
    dv = d;
    send_bit(1'b0, gap);
    for (int i = 0; i < 4; i++) send_bit(dv[i], gap);
    send_bit(p, gap);
    for (int g = 0; g < gap; g++) begin
      sin = 1'($urandom);
      tick();
    end
    bus.out_ready = rdy_stop;
    send_bit(stop, 0);
    bus.out_ready = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    cmp_cnt++;
    if ({bus.out_valid, bus.out_data, bus.out_perr, frame_err, overrun, busy} !== 9'b0) begin
      err_cnt++;
      $display("FAIL reset: outputs=%b required 000000000",
               {bus.out_valid, bus.out_data, bus.out_perr, frame_err, overrun, busy});
    end
  endtask

  task automatic test_basic();
    send_frame(4'hB, 1'b1, 1'b1, 0, 1'b0);
    cmp_cnt++;
    if ({bus.out_valid, bus.out_data, bus.out_perr, frame_err} !== {1'b1, 4'hB, 1'b0, 1'b0}) begin
      err_cnt++;
      $display("FAIL basic: valid/data/perr/ferr=%b/%h/%b/%b required 1/b/0/0",
               bus.out_valid, bus.out_data, bus.out_perr, frame_err);
    end
    drain();
    cmp_cnt++;
    if (bus.out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL drain: valid=%b required 0", bus.out_valid);
    end
  endtask

  task automatic test_parity_err();
    send_frame(4'hB, 1'b0, 1'b1, 0, 1'b0);
    cmp_cnt++;
    if ({bus.out_valid, bus.out_data, bus.out_perr} !== {1'b1, 4'hB, 1'b1}) begin
      err_cnt++;
      $display("FAIL parity_err: valid/data/perr=%b/%h/%b required 1/b/1",
               bus.out_valid, bus.out_data, bus.out_perr);
    end
    drain();
  endtask

  task automatic test_framing();
    send_frame(4'h5, 1'b0, 1'b0, 0, 1'b0);
    cmp_cnt++;
    if ({bus.out_valid, frame_err, busy} !== 3'b010) begin
      err_cnt++;
      $display("FAIL framing: valid/ferr/busy=%b required 010", {bus.out_valid, frame_err, busy});
    end
    pulse_clr();
    cmp_cnt++;
    if (frame_err !== 1'b0) begin
      err_cnt++;
      $display("FAIL frame_clr: ferr=%b required 0", frame_err);
    end
    send_frame(4'h3, 1'b0, 1'b1, 0, 1'b0);
    cmp_cnt++;
    if ({bus.out_valid, bus.out_data, bus.out_perr, frame_err} !== {1'b1, 4'h3, 1'b0, 1'b0}) begin
      err_cnt++;
      $display("FAIL frame_recover: valid/data/perr/ferr=%b/%h/%b/%b required 1/3/0/0",
               bus.out_valid, bus.out_data, bus.out_perr, frame_err);
    end
    drain();
  endtask

  task automatic test_overrun();
    send_frame(4'h1, 1'b1, 1'b1, 0, 1'b0);
    send_frame(4'h2, 1'b1, 1'b1, 0, 1'b0);
    cmp_cnt++;
    if ({bus.out_valid, bus.out_data, overrun} !== {1'b1, 4'h1, 1'b1}) begin
      err_cnt++;
      $display("FAIL overrun: valid/data/ovr=%b/%h/%b required 1/1/1",
               bus.out_valid, bus.out_data, overrun);
    end
    drain();
    pulse_clr();
    cmp_cnt++;
    if (overrun !== 1'b0) begin
      err_cnt++;
      $display("FAIL overrun_clr: ovr=%b required 0", overrun);
    end
    // Consume coincides with the second stop bit
    send_frame(4'h1, 1'b1, 1'b1, 0, 1'b0);
    send_frame(4'h2, 1'b1, 1'b1, 0, 1'b1);
    cmp_cnt++;
    if ({bus.out_valid, bus.out_data, overrun} !== {1'b1, 4'h2, 1'b0}) begin
      err_cnt++;
      $display("FAIL simul_consume: valid/data/ovr=%b/%h/%b required 1/2/0",
               bus.out_valid, bus.out_data, overrun);
    end
    drain();
  endtask

  task automatic test_sparse();
    int bad;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      send_bit(1'b1, 2);
      if (busy !== 1'b0) bad++;
    end
    cmp_cnt++;
    if (bad != 0) begin
      err_cnt++;
      $display("FAIL idle_busy: busy high after %0d idle strobes, required 0", bad);
    end
    send_frame(4'hC, 1'b0, 1'b1, 2, 1'b0);
    cmp_cnt++;
    if ({bus.out_valid, bus.out_data, bus.out_perr, frame_err} !== {1'b1, 4'hC, 1'b0, 1'b0}) begin
      err_cnt++;
      $display("FAIL sparse: valid/data/perr/ferr=%b/%h/%b/%b required 1/c/0/0",
               bus.out_valid, bus.out_data, bus.out_perr, frame_err);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    // Leave a word held and frame_err set so reset has something to clear
    send_frame(4'h7, 1'b0, 1'b0, 0, 1'b0);
    send_frame(4'h9, 1'b1, 1'b1, 0, 1'b0);
    send_bit(1'b0, 0);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    cmp_cnt++;
    if ({bus.out_valid, bus.out_data, bus.out_perr, frame_err, overrun, busy} !== 9'b0) begin
      err_cnt++;
      $display("FAIL reset_mid: outputs=%b required 000000000",
               {bus.out_valid, bus.out_data, bus.out_perr, frame_err, overrun, busy});
    end
    send_frame(4'hA, 1'b0, 1'b1, 0, 1'b0);
    cmp_cnt++;
    if ({bus.out_valid, bus.out_data, bus.out_perr, frame_err, overrun} !== {1'b1, 4'hA, 3'b000}) begin
      err_cnt++;
      $display("FAIL reset_recover: valid/data/perr/ferr/ovr=%b/%h/%b/%b/%b required 1/a/0/0/0",
               bus.out_valid, bus.out_data, bus.out_perr, frame_err, overrun);
    end
    drain();
  endtask

  // Random frames (random gaps incl. back-to-back) against the reference
  task automatic test_random();
    logic [3:0] d;
    logic       p;
    logic       stop;
    int         gap;
    for (int n = 0; n < 40; n++) begin
      d    = 4'($urandom);
      p    = ($urandom_range(3) == 0) ? ~(^d) : ^d;
      stop = ($urandom_range(7) != 0);
      gap  = $urandom_range(2);
      send_frame(d, p, stop, gap, 1'b0);
      cmp_cnt++;
      if (stop) begin
        if ({bus.out_valid, bus.out_data, bus.out_perr, frame_err, busy} !==
            {1'b1, d, ref_perr(d, p), 2'b00}) begin
          err_cnt++;
          $display("FAIL rand_good[%0d]: valid/data/perr/ferr/busy=%b/%h/%b/%b/%b required 1/%h/%b/0/0",
                   n, bus.out_valid, bus.out_data, bus.out_perr, frame_err, busy, d, ref_perr(d, p));
        end
        drain();
      end else begin
        if ({bus.out_valid, frame_err, busy} !== 3'b010) begin
          err_cnt++;
          $display("FAIL rand_ferr[%0d]: valid/ferr/busy=%b required 010",
                   n, {bus.out_valid, frame_err, busy});
        end
        pulse_clr();
      end
    end
  endtask

  initial begin
    rst_n         = 1'b1;
    sin           = 1'b1;
    sample_en     = 1'b0;
    err_clr       = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_parity_err();
    test_framing();
    test_overrun();
    test_sparse();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
